// File: rtl/xor_multiport_ram.sv
// XOR-encoded multi-port RAM: NUM_WR writers, NUM_RD readers built from
// simple dual-port banks, with power-on clear, write arbitration and forwarding.

// Simple dual-port bank: one write port, one registered read port, read-old-data.
module xor_multiport_ram_bank #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write and synchronous read; a same-edge collision returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

module xor_multiport_ram #(
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         ready,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_conflict,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [NUM_WR-1:0]     wr_lost;
  logic [NUM_WR-1:0]     wr_go;
  logic [NUM_WR-1:0]     wr_v_q;
  logic [ADDR_WIDTH-1:0] wr_a_q [NUM_WR];
  logic [DATA_WIDTH-1:0] wr_d_q [NUM_WR];
  logic [DATA_WIDTH-1:0] enc    [NUM_WR];

  logic [NUM_WR-1:0]     cw_v;
  logic [ADDR_WIDTH-1:0] cw_a [NUM_WR];
  logic [DATA_WIDTH-1:0] cw_e [NUM_WR];

  logic                  clearing;
  logic [NUM_WR-1:0]     bank_we;
  logic [ADDR_WIDTH-1:0] bank_wa [NUM_WR];
  logic [DATA_WIDTH-1:0] bank_wd [NUM_WR];

  logic [DATA_WIDTH-1:0] fb_out [NUM_WR][NUM_WR-1];
  logic [DATA_WIDTH-1:0] rb_out [NUM_WR][NUM_RD];

  logic [NUM_RD-1:0]     rd_v_q;
  logic [ADDR_WIDTH-1:0] rd_a_q [NUM_RD];
  logic [DATA_WIDTH-1:0] dec    [NUM_RD];

  // Clear sequencer: sweep every address once, then run until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Same-cycle address collisions: the lowest-indexed writer wins.
  always_comb begin
    wr_lost = '0;
    for (int unsigned i = 1; i < NUM_WR; i++)
      for (int unsigned j = 0; j < i; j++)
        if (wr_en[i] && wr_en[j] &&
            wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH])
          wr_lost[i] = 1'b1;
    wr_go = ready ? (wr_en & ~wr_lost) : '0;
  end

  // Write request stage, committed-write register and conflict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_v_q      <= '0;
      cw_v        <= '0;
      wr_conflict <= '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        wr_a_q[i] <= '0;
        wr_d_q[i] <= '0;
        cw_a[i]   <= '0;
        cw_e[i]   <= '0;
      end
    end else begin
      wr_v_q      <= wr_go;
      cw_v        <= wr_v_q;
      wr_conflict <= ready ? wr_lost : '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        wr_a_q[i] <= wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_d_q[i] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        cw_a[i]   <= wr_a_q[i];
        cw_e[i]   <= enc[i];
      end
    end
  end

  // Encode: fold in the other rows, taking a row's word committed on the
  // previous edge from its committed-write register since the bank read missed it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      enc[i] = wr_d_q[i];
      for (int unsigned k = 0; k < NUM_WR; k++)
        if (k != i) begin
          if (cw_v[k] && cw_a[k] == wr_a_q[i])
            enc[i] = enc[i] ^ cw_e[k];
          else
            enc[i] = enc[i] ^ fb_out[k][(i < k) ? i : i - 1];
        end
    end
  end

  // Bank write port: zero sweep while clearing, encoded word otherwise.
  always_comb begin
    clearing = (state == CLEAR);
    for (int unsigned r = 0; r < NUM_WR; r++) begin
      bank_we[r] = clearing | wr_v_q[r];
      bank_wa[r] = clearing ? clr_cnt : wr_a_q[r];
      bank_wd[r] = clearing ? '0 : enc[r];
    end
  end

  for (genvar r = 0; r < NUM_WR; r++) begin : g_row
    for (genvar b = 0; b < NUM_WR - 1; b++) begin : g_fb
      // Feedback bank b of row r serves writer w (every writer except r).
      localparam int W = (b < r) ? b : b + 1;
      xor_multiport_ram_bank #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we[r]),
        .waddr (bank_wa[r]),
        .wdata (bank_wd[r]),
        .raddr (wr_addr[W*ADDR_WIDTH +: ADDR_WIDTH]),
        .rdata (fb_out[r][b])
      );
    end
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      xor_multiport_ram_bank #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we[r]),
        .waddr (bank_wa[r]),
        .wdata (bank_wd[r]),
        .raddr (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .rdata (rb_out[r][p])
      );
    end
  end

  // Read request stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_q <= '0;
      for (int unsigned p = 0; p < NUM_RD; p++) rd_a_q[p] <= '0;
    end else begin
      rd_v_q <= ready ? rd_en : '0;
      for (int unsigned p = 0; p < NUM_RD; p++)
        rd_a_q[p] <= rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Decode: XOR of all rows, with the same committed-write bypass as encode.
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      dec[p] = '0;
      for (int unsigned r = 0; r < NUM_WR; r++)
        if (cw_v[r] && cw_a[r] == rd_a_q[p])
          dec[p] = dec[p] ^ cw_e[r];
        else
          dec[p] = dec[p] ^ rb_out[r][p];
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_v_q[p] ? dec[p] : '0;
    end
  end

  assign rd_valid = rd_v_q;
endmodule

// File: tb/tb_xor_multiport_ram.sv
// Bench for xor_multiport_ram: directed vectors, a word-level memory model
// checked every cycle, and literal expectations at key points.
module tb_xor_multiport_ram;
  localparam int NW = 2;
  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 2**AW;

  logic             clk;
  logic             rst_n;
  logic             ready;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_conflict;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  xor_multiport_ram #(
    .NUM_WR(NW),
    .NUM_RD(NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_conflict (wr_conflict),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: reads see writes of earlier cycles only; ready after DEPTH edges.
  logic [DW-1:0]    mdl_mem [DEPTH];
  logic             mdl_ready;
  int               mdl_cnt;
  logic [NR-1:0]    exp_valid;
  logic [NR*DW-1:0] exp_data;
  logic [NW-1:0]    exp_conf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_ready = 1'b0;
      mdl_cnt   = 0;
      exp_valid = '0;
      exp_data  = '0;
      exp_conf  = '0;
    end else begin
      exp_valid = '0;
      exp_data  = '0;
      exp_conf  = '0;
      if (mdl_ready) begin
        for (int p = 0; p < NR; p++)
          if (rd_en[p]) begin
            exp_valid[p] = 1'b1;
            exp_data[p*DW +: DW] = mdl_mem[rd_addr[p*AW +: AW]];
          end
        for (int i = 0; i < NW; i++)
          if (wr_en[i]) begin
            bit lost;
            lost = 1'b0;
            for (int j = 0; j < i; j++)
              if (wr_en[j] && wr_addr[j*AW +: AW] == wr_addr[i*AW +: AW]) lost = 1'b1;
            if (lost) exp_conf[i] = 1'b1;
            else mdl_mem[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
          end
      end else begin
        mdl_cnt++;
        if (mdl_cnt == DEPTH) begin
          mdl_ready = 1'b1;
          for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_ready", {31'd0, ready}, {31'd0, mdl_ready});
      check("cyc_rd_valid", {28'd0, rd_valid}, {28'd0, exp_valid});
      check("cyc_rd_data", rd_data, exp_data);
      check("cyc_wr_conflict", {30'd0, wr_conflict}, {30'd0, exp_conf});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    rd_en = '0;
  endtask

  task automatic set_wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*DW +: DW] = d;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rd_en[port] = 1'b1;
    rd_addr[port*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] get_rd(input int port);
    return rd_data[port*DW +: DW];
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (ready !== 1'b1) $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    wr_en   = '0;
    rd_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    step();
    chk_on = 1'b1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd_valid", {28'd0, rd_valid}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    step();
    #2 rst_n = 1'b1;

    // Clear sequence length and cleared contents.
    wait_ready(n);
    check("clear_cycles", n, DEPTH);
    for (int g = 0; g < DEPTH / NR; g++) begin
      idle();
      for (int p = 0; p < NR; p++) set_rd(p, AW'(g * NR + p));
      step();
      check("clear_rd_valid", {28'd0, rd_valid}, 32'hF);
      for (int p = 0; p < NR; p++) check("clear_read", {24'd0, get_rd(p)}, 32'h00);
    end

    // Two writers, different addresses.
    idle();
    set_wr(0, 4'd3, 8'hA5);
    set_wr(1, 4'd7, 8'h3C);
    step();
    idle();
    step();
    set_rd(0, 4'd3);
    set_rd(3, 4'd7);
    step();
    check("dual_wr_rd0", {24'd0, get_rd(0)}, 32'hA5);
    check("dual_wr_rd3", {24'd0, get_rd(3)}, 32'h3C);
    check("dual_wr_valid", {28'd0, rd_valid}, 32'h9);
    idle();
    step();
    check("valid_drops", {28'd0, rd_valid}, 32'h0);

    // Back-to-back writes to one address from different ports.
    set_wr(0, 4'd5, 8'h11);
    step();
    idle();
    set_wr(1, 4'd5, 8'h22);
    step();
    idle();
    set_rd(1, 4'd5);
    step();
    check("b2b_fwd_read", {24'd0, get_rd(1)}, 32'h22);
    idle();
    set_rd(2, 4'd5);
    step();
    check("b2b_ram_read", {24'd0, get_rd(2)}, 32'h22);

    // Read ordering around a single write.
    idle();
    set_wr(0, 4'd9, 8'h5A);
    set_rd(0, 4'd9);
    step();
    check("order_same_cycle", {24'd0, get_rd(0)}, 32'h00);
    idle();
    set_rd(1, 4'd9);
    step();
    check("order_next_cycle", {24'd0, get_rd(1)}, 32'h5A);
    idle();
    set_rd(2, 4'd9);
    step();
    check("order_two_later", {24'd0, get_rd(2)}, 32'h5A);

    // Write-write conflict.
    idle();
    set_wr(0, 4'd2, 8'h01);
    set_wr(1, 4'd2, 8'h02);
    step();
    check("conflict_pulse", {30'd0, wr_conflict}, 32'h2);
    idle();
    step();
    check("conflict_clears", {30'd0, wr_conflict}, 32'h0);
    set_rd(0, 4'd2);
    step();
    check("conflict_winner", {24'd0, get_rd(0)}, 32'h01);

    // Mid-stream reset loses contents; accesses during clear are ignored.
    idle();
    set_wr(1, 4'd1, 8'h77);
    step();
    idle();
    step();
    set_rd(0, 4'd1);
    step();
    check("pre_reset_read", {24'd0, get_rd(0)}, 32'h77);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_ready", {31'd0, ready}, 32'd0);
    check("mid_reset_valid", {28'd0, rd_valid}, 32'd0);
    check("mid_reset_data", rd_data, 32'd0);
    set_wr(0, 4'd1, 8'hEE);
    step();
    step();
    #2 rst_n = 1'b1;
    wait_ready(n);
    idle();
    check("reclear_cycles", n, DEPTH);
    set_rd(0, 4'd1);
    step();
    check("post_reset_read", {24'd0, get_rd(0)}, 32'h00);
    check("post_reset_valid", {28'd0, rd_valid}, 32'h1);
    idle();
    step();
    step();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
